// File: rtl/mcycle_control_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mcycle_control_unit_if : decode inputs and registered EX-stage controls
// Revision : 1.0
// ---------------------------------------------------------------------------
interface mcycle_control_unit_if;
   logic       enable;
   logic       flush;
   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [1:0] alu_op;
   logic       reg_dst;
   logic       branch;
   logic       mem_read;
   logic       mem_2_reg;
   logic       mem_write;
   logic       alu_src;
   logic       reg_write;
   logic       jump;
   logic       mul_sel;
   logic       stall;
   logic       mul_done;

   modport master (
      output enable, flush, opcode, funct7,
      input  alu_op, reg_dst, branch, mem_read, mem_2_reg, mem_write,
             alu_src, reg_write, jump, mul_sel, stall, mul_done
   );

   modport slave (
      input  enable, flush, opcode, funct7,
      output alu_op, reg_dst, branch, mem_read, mem_2_reg, mem_write,
             alu_src, reg_write, jump, mul_sel, stall, mul_done
   );
endinterface
`default_nettype wire

// File: rtl/mcycle_control_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mcycle_control_unit : registered decode with multi-cycle multiply stall FSM
// Revision : 1.0
// ---------------------------------------------------------------------------
module mcycle_control_unit #(
   parameter int         MUL_CYCLES = 3,
   parameter logic [6:0] MUL_FUNCT7 = 7'b0000001
) (
   input  logic                        clk,
   input  logic                        arst_n,
   mcycle_control_unit_if.slave        bus
);

   localparam logic [6:0] c_op_rtype = 7'b0110011;
   localparam logic [6:0] c_op_alui  = 7'b0010011;
   localparam logic [6:0] c_op_beq   = 7'b1100011;
   localparam logic [6:0] c_op_jal   = 7'b1101111;
   localparam logic [6:0] c_op_load  = 7'b0000011;
   localparam logic [6:0] c_op_store = 7'b0100011;

   localparam int                c_cnt_w    = $clog2(MUL_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MUL_CYCLES - 1);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       branch;
      logic       mem_read;
      logic       mem_2_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic       jump;
      logic       mul_sel;
   } ctrl_t;

   localparam ctrl_t c_bubble = '0;

   state_t             r_state, w_state;
   logic [c_cnt_w-1:0] r_cnt,   w_cnt;
   ctrl_t              r_ctrl,  w_ctrl;
   logic               r_mul_done, w_mul_done;
   logic               w_is_mul;

   function automatic ctrl_t f_decode(input logic [6:0] op);
      ctrl_t c;
      c = c_bubble;
      case (op)
         c_op_rtype: begin c.reg_write = 1'b1; c.alu_op = 2'b10; end
         c_op_alui:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
         c_op_beq:   begin c.branch = 1'b1; c.alu_op = 2'b01; end
         c_op_jal:   c.jump = 1'b1;
         c_op_load:  begin
            c.alu_src   = 1'b1;
            c.mem_2_reg = 1'b1;
            c.reg_write = 1'b1;
            c.mem_read  = 1'b1;
         end
         c_op_store: begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
         default:    c.alu_op = 2'b10;
      endcase
      return c;
   endfunction

   assign w_is_mul = (bus.opcode == c_op_rtype) && (bus.funct7 == MUL_FUNCT7);

   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_ctrl     = r_ctrl;
      w_mul_done = 1'b0;
      if (bus.flush) begin
         w_state = IDLE;
         w_cnt   = '0;
         w_ctrl  = c_bubble;
      end else begin
         case (r_state)
            IDLE: begin
               if (!bus.enable) begin
                  w_ctrl = c_bubble;
               end else begin
                  w_ctrl = f_decode(bus.opcode);
                  if (w_is_mul) begin
                     w_ctrl.mul_sel = 1'b1;
                     // A single-cycle multiply completes right away, no stall.
                     if (MUL_CYCLES > 1) begin
                        w_ctrl.reg_write = 1'b0;
                        w_state          = MUL_BUSY;
                        w_cnt            = c_cnt_init;
                     end else begin
                        w_mul_done = 1'b1;
                     end
                  end
               end
            end
            MUL_BUSY: begin
               if (r_cnt <= c_cnt_w'(1)) begin
                  w_ctrl.reg_write = 1'b1;
                  w_mul_done       = 1'b1;
                  w_state          = IDLE;
                  w_cnt            = '0;
               end else begin
                  w_cnt = r_cnt - 1'b1;
               end
            end
            default: begin
               w_state = IDLE;
               w_cnt   = '0;
               w_ctrl  = c_bubble;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_ctrl     <= c_bubble;
         r_mul_done <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_ctrl     <= w_ctrl;
         r_mul_done <= w_mul_done;
      end
   end

   assign bus.alu_op    = r_ctrl.alu_op;
   assign bus.reg_dst   = r_ctrl.reg_dst;
   assign bus.branch    = r_ctrl.branch;
   assign bus.mem_read  = r_ctrl.mem_read;
   assign bus.mem_2_reg = r_ctrl.mem_2_reg;
   assign bus.mem_write = r_ctrl.mem_write;
   assign bus.alu_src   = r_ctrl.alu_src;
   assign bus.reg_write = r_ctrl.reg_write;
   assign bus.jump      = r_ctrl.jump;
   assign bus.mul_sel   = r_ctrl.mul_sel;
   assign bus.mul_done  = r_mul_done;
   // State-only decode keeps the stall path free of input timing.
   assign bus.stall     = (r_state == MUL_BUSY);

endmodule
`default_nettype wire

// File: doc/mcycle_control_unit.md
MCYCLE_CONTROL_UNIT -- requirements
Module: mcycle_control_unit

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 3, setting the multiply latency in cycles (legal 1..15).
REQ-002 The block SHALL have parameter MUL_FUNCT7, default 7'b0000001, the funct7 value that marks an R-type as multiply.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port arst_n  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port enable  input  1  decode-stage instruction valid.
REQ-006 The block SHALL have port flush  input  1  synchronous squash of the ID/EX control stage.
REQ-007 The block SHALL have port opcode  input  7  instruction bits [6:0].
REQ-008 The block SHALL have port funct7  input  7  instruction bits [31:25].
REQ-009 The block SHALL have ports alu_op (output, 2), and reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump, mul_sel (output, 1 each); all are registered EX-stage controls.
REQ-010 The block SHALL have port stall  output  1  holds PC and IF/ID while a multiply is in progress.
REQ-011 The block SHALL have port mul_done  output  1  single-cycle pulse in the final multiply cycle.

Function
REQ-012 Decode SHALL be: 0110011 R-type -> reg_write=1, alu_op=10; 0010011 ALU-I -> alu_src=1, reg_write=1, alu_op=00; 1100011 BEQ -> branch=1, alu_op=01; 1101111 JAL -> jump=1, alu_op=00; 0000011 LOAD -> alu_src=1, mem_2_reg=1, reg_write=1, mem_read=1, alu_op=00; 0100011 STORE -> alu_src=1, mem_write=1, alu_op=00; any other opcode -> all 1-bit controls 0, alu_op=10. Every control not listed for an opcode SHALL be 0.
REQ-013 The registered outputs SHALL reflect the instruction decoded on the previous edge, giving a latency of 1 cycle.
REQ-014 A bubble SHALL drive all 1-bit outputs to 0 and alu_op to 00.
REQ-015 The FSM SHALL have the states IDLE and MUL_BUSY, with a counter cnt of width clog2(MUL_CYCLES+1).
REQ-016 In IDLE with enable=1 and a non-multiply instruction, the decoded controls SHALL be registered and the FSM SHALL stay in IDLE.
REQ-017 In IDLE with enable=0, a bubble SHALL be registered.
REQ-018 In IDLE with enable=1, opcode=0110011 and funct7=MUL_FUNCT7, the block SHALL:
- register the R-type controls with mul_sel=1;
- register reg_write=0 when MUL_CYCLES>1;
- enter MUL_BUSY with cnt=MUL_CYCLES-1.
REQ-019 In MUL_BUSY:
- stall SHALL be 1;
- the registered outputs SHALL hold their values;
- opcode, funct7 and enable SHALL be ignored;
- cnt SHALL decrement every cycle.
REQ-020 When cnt reaches 1 in MUL_BUSY, the next edge SHALL:
- set reg_write=1 and mul_done=1 for exactly one cycle;
- return the FSM to IDLE.
In that cycle stall SHALL be 0, and a new instruction SHALL be accepted at the following edge.
REQ-021 When MUL_CYCLES=1, a multiply SHALL behave like any R-type: mul_sel=1, reg_write=1, mul_done=1 for one cycle, and no stall.
REQ-022 stall SHALL be a function of state only, with no combinational path from the inputs.
REQ-023 flush SHALL take priority over enable and the FSM state: on a flush edge, a bubble SHALL be registered, the FSM SHALL go to IDLE, cnt SHALL clear, and mul_done SHALL stay 0.
REQ-024 A multiply aborted by flush SHALL produce no reg_write pulse.

Reset
REQ-025 While arst_n=0, every output SHALL be forced to the bubble values, with stall=0 and mul_done=0, the FSM SHALL be in IDLE, and cnt SHALL be 0, independent of clk.
REQ-026 Asserting reset mid-multiply SHALL abort it; after release the first enabled instruction SHALL decode normally.

Verification
REQ-027 Decode sweep: each of the 6 opcodes plus 7'h7F with enable=1 -> the REQ-012 values one cycle later, and the bubble when enable=0.
REQ-028 MUL, MUL_CYCLES=3: the MUL is accepted at edge 0, then:
- stall=1 in cycles 1-2;
- mul_sel=1 in cycles 1-3;
- reg_write=0 in cycles 1-2, then reg_write=1 and mul_done=1 in cycle 3;
- an ADDI presented during cycles 1-2 is ignored, and an ADDI presented in cycle 3 appears in cycle 4.
REQ-029 Back-to-back MULs -> two independent 3-cycle sequences with exactly one mul_done per MUL.
REQ-030 flush in cycle 2 of a MUL -> bubble in cycle 3, stall=0, no mul_done, and IDLE.
REQ-031 arst_n pulled low asynchronously mid-MUL -> outputs go to the bubble immediately; a LOAD after release -> mem_read=1, mem_2_reg=1.
REQ-032 MUL_CYCLES=1 build: a MUL -> stall never asserts; mul_done=1 and reg_write=1 one cycle after issue.
